pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_return_stack.sv | 62 ++++++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC operation
// encodings and the decoded-operation type.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  localparam logic [2:0] OP_SEQ_C  = 3'd0;
  localparam logic [2:0] OP_BR_C   = 3'd1;
  localparam logic [2:0] OP_JMP_C  = 3'd2;
  localparam logic [2:0] OP_CALL_C = 3'd3;
  localparam logic [2:0] OP_RET_C  = 3'd4;

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// so the most recent DEPTH addresses always come back in LIFO order.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] top_idx;
  logic [CW-1:0] count_q, count_d;

  // ptr_q points at the next free slot; the top of stack sits just below it.
  assign top_idx = ptr_q - 1'b1;
  assign top     = mem_q[top_idx];
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + 1'b1;
      if (!full) count_d = count_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; it is unreachable while count_q is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered PC with sequential, relative-branch,
// jump, call and return operations backed by a circular return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int OFF_WIDTH = 16,
  parameter int STEP      = 1,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   op,
  input  logic [OFF_WIDTH-1:0]         offset,
  input  logic [PC_WIDTH-1:0]          target,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic                       ovf_q, ovf_d;
  logic                       unf_q, unf_d;
  logic                       push, pop;
  logic [PC_WIDTH-1:0]        ras_top;
  logic [PC_WIDTH-1:0]        pc_seq;
  logic [PC_WIDTH-1:0]        off_ext;
  logic signed [OFF_WIDTH-1:0] off_s;
  op_e                        op_sel;

  // A sized cast of a signed value sign-extends for any OFF_WIDTH <= PC_WIDTH.
  assign off_s   = offset;
  assign off_ext = PC_WIDTH'(off_s);
  assign pc_seq  = pc_q + PC_WIDTH'(STEP);
  assign op_sel  = op_e'(op);

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (!stall) begin
      case (op_sel)
        OP_BR:   pc_d = pc_seq + off_ext;
        OP_JMP:  pc_d = target;
        OP_CALL: begin
          push = 1'b1;
          pc_d = target;
          if (ras_full) ovf_d = 1'b1;
        end
        OP_RET: begin
          if (ras_empty) begin
            pc_d  = pc_seq;
            unf_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        default: pc_d = pc_seq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_return_stack #(
    .W     (PC_WIDTH),
    .DEPTH (RAS_DEPTH),
    .CW    (CW)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  op;
  logic [15:0] offset;
  logic [31:0] target;
  logic [31:0] pc;
  logic [3:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        ras_overflow;
  logic        ras_underflow;

  int n_assert;
  int n_fail;

  pc_sequencer #(
    .PC_WIDTH  (32),
    .OFF_WIDTH (16),
    .STEP      (1),
    .RAS_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .op            (op),
    .offset        (offset),
    .target        (target),
    .pc            (pc),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one op, then sample #1 after the edge that consumes it
  task automatic do_op(input logic [2:0] o, input logic [15:0] off, input logic [31:0] tgt);
    op     = o;
    offset = off;
    target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    op       = OP_SEQ_C;
    offset   = '0;
    target   = '0;

    #12;
    chk("reset_pc", pc, 32'h0);
    chk("reset_count", 32'(ras_count), 32'd0);
    chk("reset_full", 32'(ras_full), 32'd0);
    chk("reset_empty", 32'(ras_empty), 32'd1);
    chk("reset_ovf", 32'(ras_overflow), 32'd0);
    chk("reset_unf", 32'(ras_underflow), 32'd0);
    reset = 1'b0;

    // sequential stepping
    chk("seq0", pc, 32'h0);
    do_op(OP_SEQ_C, 16'h0, 32'h0); chk("seq1", pc, 32'h1);
    do_op(OP_SEQ_C, 16'h0, 32'h0); chk("seq2", pc, 32'h2);
    do_op(OP_SEQ_C, 16'h0, 32'h0); chk("seq3", pc, 32'h3);
    do_op(3'd7, 16'h0, 32'h0);     chk("reserved_as_seq", pc, 32'h4);

    // relative branches
    do_op(OP_JMP_C, 16'h0, 32'h10);  chk("jmp_10", pc, 32'h10);
    do_op(OP_BR_C, 16'hFFFC, 32'h0); chk("br_neg", pc, 32'h0D);
    do_op(OP_BR_C, 16'h0005, 32'h0); chk("br_pos", pc, 32'h13);

    // call / return
    do_op(OP_JMP_C, 16'h0, 32'h20);   chk("jmp_20", pc, 32'h20);
    do_op(OP_CALL_C, 16'h0, 32'h100); chk("call_pc", pc, 32'h100);
    chk("call_count", 32'(ras_count), 32'd1);
    do_op(OP_SEQ_C, 16'h0, 32'h0);
    do_op(OP_SEQ_C, 16'h0, 32'h0);    chk("sub_seq", pc, 32'h102);
    do_op(OP_RET_C, 16'h0, 32'h0);    chk("ret_pc", pc, 32'h21);
    chk("ret_count", 32'(ras_count), 32'd0);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // overflow / underflow
    do_reset();
    chk("rst2_pc", pc, 32'h0);
    for (int i = 0; i < 9; i++) begin
      do_op(OP_CALL_C, 16'h0, 32'(i + 1));
      if (i == 7) begin
        chk("full_at_8", 32'(ras_full), 32'd1);
        chk("no_ovf_at_8", 32'(ras_overflow), 32'd0);
      end
    end
    chk("call9_pc", pc, 32'h9);
    chk("ovf_set", 32'(ras_overflow), 32'd1);
    chk("ovf_full", 32'(ras_full), 32'd1);
    chk("ovf_count", 32'(ras_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      do_op(OP_RET_C, 16'h0, 32'h0);
      chk($sformatf("ret_lifo_%0d", i), pc, 32'(9 - i));
    end
    chk("lifo_empty", 32'(ras_empty), 32'd1);
    chk("lifo_no_unf", 32'(ras_underflow), 32'd0);
    do_op(OP_RET_C, 16'h0, 32'h0);
    chk("unf_pc", pc, 32'h3);
    chk("unf_set", 32'(ras_underflow), 32'd1);
    chk("unf_count", 32'(ras_count), 32'd0);
    chk("ovf_sticky", 32'(ras_overflow), 32'd1);

    // wrap-around
    do_op(OP_JMP_C, 16'h0, 32'hFFFF_FFFF); chk("jmp_max", pc, 32'hFFFF_FFFF);
    do_op(OP_SEQ_C, 16'h0, 32'h0);         chk("seq_wrap", pc, 32'h0);

    // stall holds everything
    do_op(OP_CALL_C, 16'h0, 32'h100); chk("pre_stall_pc", pc, 32'h100);
    stall = 1'b1;
    do_op(OP_JMP_C, 16'h0, 32'h55);   chk("stall1_pc", pc, 32'h100);
    do_op(OP_JMP_C, 16'h0, 32'h55);   chk("stall2_pc", pc, 32'h100);
    chk("stall_count", 32'(ras_count), 32'd1);
    do_op(OP_RET_C, 16'h0, 32'h0);    chk("stall_ret_pc", pc, 32'h100);
    chk("stall_ret_count", 32'(ras_count), 32'd1);
    stall = 1'b0;
    do_op(OP_RET_C, 16'h0, 32'h0);    chk("post_stall_ret", pc, 32'h1);

    // asynchronous reset mid-cycle
    do_op(OP_JMP_C, 16'h0, 32'h77);
    op = OP_SEQ_C;
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_ovf", 32'(ras_overflow), 32'd0);
    chk("async_unf", 32'(ras_underflow), 32'd0);
    chk("async_empty", 32'(ras_empty), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_op(OP_SEQ_C, 16'h0, 32'h0);    chk("post_reset_seq", pc, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
